// File: rtl/tdp_ram_pkg.sv
// Shared types and defaults for the true-dual-port RAM with clear sequencer.
package tdp_ram_pkg;

    typedef enum logic [0:0] {
        RD_FIRST = 1'b0,
        WR_FIRST = 1'b1
    } rd_mode_e;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    localparam int unsigned DEF_NUM_COL    = 4;
    localparam int unsigned DEF_COL_WIDTH  = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 10;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: sweeps every word address once, then hands the array to the ports.
module ram_clear_seq
    import tdp_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter bit          CLEAR_RST  = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear_req,
    output logic                  o_ready,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr,
    output clr_state_e            o_state
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam clr_state_e            RST_STATE = clr_state_e'(CLEAR_RST ? CLEAR : READY);

    clr_state_e            r_state;
    clr_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;
    logic                  r_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                if (i_clear_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = RST_STATE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ready is registered so it stays low while reset is held even when no sweep follows.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RST_STATE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == READY);
        end
    end

    assign o_ready    = r_ready;
    assign o_clr_we   = (r_state == CLEAR);
    assign o_clr_addr = r_cnt;
    assign o_state    = r_state;

endmodule

// File: rtl/tdp_ram_clr.sv
// True-dual-port byte-write RAM with selectable read mode, optional output register
// and a zero-fill (CLEAR_VAL) sweep after reset or on request.
module tdp_ram_clr
    import tdp_ram_pkg::*;
#(
    parameter int unsigned                         NUM_COL    = DEF_NUM_COL,
    parameter int unsigned                         COL_WIDTH  = DEF_COL_WIDTH,
    parameter int unsigned                         ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter rd_mode_e                            RD_MODE    = RD_FIRST,
    parameter int unsigned                         OUT_REG    = 0,
    parameter int unsigned                         CLEAR_RST  = 1,
    parameter logic [NUM_COL*COL_WIDTH-1:0]        CLEAR_VAL  = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_req,
    output logic                          ready,
    output logic                          collision,
    input  logic                          en_a,
    input  logic [NUM_COL-1:0]            wen_a,
    input  logic [ADDR_WIDTH-1:0]         addr_a,
    input  logic [NUM_COL*COL_WIDTH-1:0]  din_a,
    output logic [NUM_COL*COL_WIDTH-1:0]  dout_a,
    output logic                          dout_vld_a,
    input  logic                          en_b,
    input  logic [NUM_COL-1:0]            wen_b,
    input  logic [ADDR_WIDTH-1:0]         addr_b,
    input  logic [NUM_COL*COL_WIDTH-1:0]  din_b,
    output logic [NUM_COL*COL_WIDTH-1:0]  dout_b,
    output logic                          dout_vld_b
);

    localparam int unsigned DATA_WIDTH = NUM_COL * COL_WIDTH;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] merge_cols(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NUM_COL-1:0]    col_we
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NUM_COL; i++) begin
            if (col_we[i]) begin
                res[i*COL_WIDTH +: COL_WIDTH] = new_word[i*COL_WIDTH +: COL_WIDTH];
            end
        end
        return res;
    endfunction

    logic                  w_ready;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    clr_state_e            w_state;
    logic                  w_port_ok;
    logic                  w_rd_a;
    logic                  w_rd_b;
    logic [NUM_COL-1:0]    w_we_a;
    logic [NUM_COL-1:0]    w_we_b;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q1_a;
    logic [DATA_WIDTH-1:0] r_q1_b;
    logic                  r_vld1_a;
    logic                  r_vld1_b;
    logic                  r_collision;

    ram_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CLEAR_RST  (CLEAR_RST != 0)
    ) u_clear_seq (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clear_req (clear_req),
        .o_ready     (w_ready),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr),
        .o_state     (w_state)
    );

    // Ports act only while the sequencer has published ready; the cycle that
    // raises clear_req still counts as a normal port cycle.
    assign w_port_ok = w_ready && (w_state == READY);
    assign w_rd_a    = w_port_ok && en_a;
    assign w_rd_b    = w_port_ok && en_b;
    assign w_we_a    = wen_a & {NUM_COL{w_rd_a}};
    assign w_we_b    = wen_b & {NUM_COL{w_rd_b}};

    // Port B columns are written first so port A overrides on overlapping columns.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= CLEAR_VAL;
        end else begin
            for (int i = 0; i < NUM_COL; i++) begin
                if (w_we_b[i]) begin
                    r_mem[addr_b][i*COL_WIDTH +: COL_WIDTH] <= din_b[i*COL_WIDTH +: COL_WIDTH];
                end
            end
            for (int i = 0; i < NUM_COL; i++) begin
                if (w_we_a[i]) begin
                    r_mem[addr_a][i*COL_WIDTH +: COL_WIDTH] <= din_a[i*COL_WIDTH +: COL_WIDTH];
                end
            end
        end
    end

    // Reads sample the pre-write array, so the other port always sees old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q1_a      <= '0;
            r_q1_b      <= '0;
            r_vld1_a    <= 1'b0;
            r_vld1_b    <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_vld1_a    <= w_rd_a;
            r_vld1_b    <= w_rd_b;
            r_collision <= (addr_a == addr_b) && (|(w_we_a & w_we_b));
            if (w_rd_a) begin
                r_q1_a <= (RD_MODE == WR_FIRST) ? merge_cols(r_mem[addr_a], din_a, w_we_a)
                                                : r_mem[addr_a];
            end
            if (w_rd_b) begin
                r_q1_b <= (RD_MODE == WR_FIRST) ? merge_cols(r_mem[addr_b], din_b, w_we_b)
                                                : r_mem[addr_b];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_q2_a;
            logic [DATA_WIDTH-1:0] r_q2_b;
            logic                  r_vld2_a;
            logic                  r_vld2_b;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q2_a   <= '0;
                    r_q2_b   <= '0;
                    r_vld2_a <= 1'b0;
                    r_vld2_b <= 1'b0;
                end else begin
                    r_vld2_a <= r_vld1_a;
                    r_vld2_b <= r_vld1_b;
                    if (r_vld1_a) begin
                        r_q2_a <= r_q1_a;
                    end
                    if (r_vld1_b) begin
                        r_q2_b <= r_q1_b;
                    end
                end
            end

            assign dout_a     = r_q2_a;
            assign dout_b     = r_q2_b;
            assign dout_vld_a = r_vld2_a;
            assign dout_vld_b = r_vld2_b;
        end else begin : g_no_out_reg
            assign dout_a     = r_q1_a;
            assign dout_b     = r_q1_b;
            assign dout_vld_a = r_vld1_a;
            assign dout_vld_b = r_vld1_b;
        end
    endgenerate

    assign ready     = w_ready;
    assign collision = r_collision;

endmodule

// File: tb/tb_tdp_ram_clr.sv
// Directed bench: two instances share stimulus, one RD_FIRST/latency 1, one WR_FIRST/latency 2.
module tb_tdp_ram_clr;
    import tdp_ram_pkg::*;

    localparam logic [31:0] CV0 = 32'h0000_0000;
    localparam logic [31:0] CV1 = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear_req = 1'b0;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic [3:0]  wen_a = '0;
    logic [3:0]  wen_b = '0;
    logic [3:0]  addr_a = '0;
    logic [3:0]  addr_b = '0;
    logic [31:0] din_a = '0;
    logic [31:0] din_b = '0;

    logic        ready0, coll0, vld_a0, vld_b0;
    logic [31:0] dout_a0, dout_b0;
    logic        ready1, coll1, vld_a1, vld_b1;
    logic [31:0] dout_a1, dout_b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tdp_ram_clr #(
        .ADDR_WIDTH (4), .RD_MODE (RD_FIRST), .OUT_REG (0), .CLEAR_RST (1), .CLEAR_VAL (CV0)
    ) dut0 (
        .clk (clk), .rst (rst), .clear_req (clear_req), .ready (ready0), .collision (coll0),
        .en_a (en_a), .wen_a (wen_a), .addr_a (addr_a), .din_a (din_a),
        .dout_a (dout_a0), .dout_vld_a (vld_a0),
        .en_b (en_b), .wen_b (wen_b), .addr_b (addr_b), .din_b (din_b),
        .dout_b (dout_b0), .dout_vld_b (vld_b0)
    );

    tdp_ram_clr #(
        .ADDR_WIDTH (4), .RD_MODE (WR_FIRST), .OUT_REG (1), .CLEAR_RST (1), .CLEAR_VAL (CV1)
    ) dut1 (
        .clk (clk), .rst (rst), .clear_req (clear_req), .ready (ready1), .collision (coll1),
        .en_a (en_a), .wen_a (wen_a), .addr_a (addr_a), .din_a (din_a),
        .dout_a (dout_a1), .dout_vld_a (vld_a1),
        .en_b (en_b), .wen_b (wen_b), .addr_b (addr_b), .din_b (din_b),
        .dout_b (dout_b1), .dout_vld_b (vld_b1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en_a = 1'b0; en_b = 1'b0; wen_a = '0; wen_b = '0; clear_req = 1'b0;
    endtask

    task automatic wr(input bit port, input logic [3:0] addr, input logic [31:0] data,
                      input logic [3:0] wen);
        if (port) begin
            en_b = 1'b1; wen_b = wen; addr_b = addr; din_b = data;
        end else begin
            en_a = 1'b1; wen_a = wen; addr_a = addr; din_a = data;
        end
        step();
        idle();
        step();
    endtask

    task automatic rd(input bit port, input logic [3:0] addr, input logic [31:0] e0,
                      input logic [31:0] e1, input string tag);
        if (port) begin
            en_b = 1'b1; addr_b = addr;
        end else begin
            en_a = 1'b1; addr_a = addr;
        end
        step();
        idle();
        chk({tag, "_vld0_lat1"}, 32'(port ? vld_b0 : vld_a0), 32'd1);
        chk({tag, "_dout0"}, port ? dout_b0 : dout_a0, e0);
        chk({tag, "_vld1_early"}, 32'(port ? vld_b1 : vld_a1), 32'd0);
        step();
        chk({tag, "_vld0_pulse"}, 32'(port ? vld_b0 : vld_a0), 32'd0);
        chk({tag, "_dout0_hold"}, port ? dout_b0 : dout_a0, e0);
        chk({tag, "_vld1_lat2"}, 32'(port ? vld_b1 : vld_a1), 32'd1);
        chk({tag, "_dout1"}, port ? dout_b1 : dout_a1, e1);
    endtask

    initial begin
        // Reset values
        repeat (3) step();
        chk("rst_ready0", 32'(ready0), 32'd0);
        chk("rst_ready1", 32'(ready1), 32'd0);
        chk("rst_coll0", 32'(coll0), 32'd0);
        chk("rst_vld_a0", 32'(vld_a0), 32'd0);
        chk("rst_vld_b1", 32'(vld_b1), 32'd0);
        chk("rst_dout_a0", dout_a0, 32'd0);
        chk("rst_dout_b1", dout_b1, 32'd0);

        // Sweep after reset: ready stays low for exactly 16 cycles
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("init_ready0_k%0d", k), 32'(ready0), 32'(k >= 16));
            chk($sformatf("init_ready1_k%0d", k), 32'(ready1), 32'(k >= 16));
        end
        for (int a = 0; a < 16; a++) begin
            rd(a[0], 4'(a), CV0, CV1, $sformatf("init_rd%0d", a));
        end

        // Basic write then read, latency 1 and 2
        wr(1'b0, 4'd5, 32'hDEAD_BEEF, 4'hF);
        rd(1'b0, 4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "wr5");

        // Same-port and cross-port read-during-write
        wr(1'b0, 4'd3, 32'h1122_3344, 4'hF);
        en_a = 1'b1; wen_a = 4'b0011; addr_a = 4'd3; din_a = 32'hAABB_CCDD;
        en_b = 1'b1; wen_b = 4'b0000; addr_b = 4'd3;
        step();
        idle();
        chk("rdw_a_rdfirst", dout_a0, 32'h1122_3344);
        chk("rdw_b_cross0", dout_b0, 32'h1122_3344);
        step();
        chk("rdw_a_wrfirst", dout_a1, 32'h1122_CCDD);
        chk("rdw_b_cross1", dout_b1, 32'h1122_3344);
        rd(1'b1, 4'd3, 32'h1122_CCDD, 32'h1122_CCDD, "rdw_after");

        // Dual write, overlapping columns (A wins, collision pulse)
        en_a = 1'b1; wen_a = 4'b0011; addr_a = 4'd7; din_a = 32'hAAAA_AAAA;
        en_b = 1'b1; wen_b = 4'b0110; addr_b = 4'd7; din_b = 32'hBBBB_BBBB;
        step();
        idle();
        chk("coll_pulse0", 32'(coll0), 32'd1);
        chk("coll_pulse1", 32'(coll1), 32'd1);
        step();
        chk("coll_end0", 32'(coll0), 32'd0);
        chk("coll_end1", 32'(coll1), 32'd0);
        rd(1'b0, 4'd7, 32'h00BB_AAAA, 32'hA5BB_AAAA, "dual7");

        // Dual write, disjoint columns (no collision)
        en_a = 1'b1; wen_a = 4'b0011; addr_a = 4'd8; din_a = 32'hAAAA_AAAA;
        en_b = 1'b1; wen_b = 4'b1100; addr_b = 4'd8; din_b = 32'hBBBB_BBBB;
        step();
        idle();
        chk("nocoll0", 32'(coll0), 32'd0);
        chk("nocoll1", 32'(coll1), 32'd0);
        step();
        rd(1'b1, 4'd8, 32'hBBBB_AAAA, 32'hBBBB_AAAA, "dual8");

        // Fill, then clear on request while hammering both ports
        for (int a = 0; a < 16; a++) begin
            wr(1'b0, 4'(a), 32'h1000_0000 | 32'(a), 4'hF);
        end
        clear_req = 1'b1; en_a = 1'b1; wen_a = 4'h0; addr_a = 4'd2;
        step();
        chk("clr_req_ready0", 32'(ready0), 32'd0);
        chk("clr_req_ready1", 32'(ready1), 32'd0);
        chk("clr_req_rd0", dout_a0, 32'h1000_0002);
        for (int k = 1; k <= 16; k++) begin
            clear_req = 1'b1;
            en_a = 1'b1; wen_a = 4'hF; addr_a = 4'(k); din_a = 32'hFFFF_FFFF;
            en_b = 1'b1; wen_b = 4'hF; addr_b = 4'(k); din_b = 32'hEEEE_EEEE;
            step();
            chk($sformatf("clr_ready0_k%0d", k), 32'(ready0), 32'(k >= 16));
            chk($sformatf("clr_ready1_k%0d", k), 32'(ready1), 32'(k >= 16));
            chk($sformatf("clr_vld_a0_k%0d", k), 32'(vld_a0), 32'd0);
            chk($sformatf("clr_vld_b0_k%0d", k), 32'(vld_b0), 32'd0);
            chk($sformatf("clr_coll0_k%0d", k), 32'(coll0), 32'd0);
            if (k == 1) begin
                chk("clr_req_rd1", dout_a1, 32'h1000_0002);
            end else begin
                chk($sformatf("clr_vld_a1_k%0d", k), 32'(vld_a1), 32'd0);
            end
        end
        idle();
        for (int a = 0; a < 16; a++) begin
            rd(a[0], 4'(a), CV0, CV1, $sformatf("clr_rd%0d", a));
        end

        // Reset in the middle of a sweep restarts it from word 0
        wr(1'b0, 4'd12, 32'h1234_5678, 4'hF);
        rd(1'b0, 4'd12, 32'h1234_5678, 32'h1234_5678, "pre_rst12");
        clear_req = 1'b1;
        step();
        idle();
        repeat (8) step();
        rst = 1'b1;
        #1;
        chk("midrst_dout_a0", dout_a0, 32'd0);
        chk("midrst_dout_a1", dout_a1, 32'd0);
        chk("midrst_ready0", 32'(ready0), 32'd0);
        chk("midrst_ready1", 32'(ready1), 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            chk($sformatf("rerun_ready0_k%0d", k), 32'(ready0), 32'(k >= 16));
            chk($sformatf("rerun_ready1_k%0d", k), 32'(ready1), 32'(k >= 16));
        end
        rd(1'b0, 4'd12, CV0, CV1, "post_rst12");
        rd(1'b1, 4'd15, CV0, CV1, "post_rst15");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
